// File: rtl/block_buffer.sv
// block_buffer
// Collects the byte stream coming from the I/O interface into one 64-byte
// BLAKE2s message block. Lanes that are never written stay zero, which gives
// the padding of a short final block. The running byte counter t is tracked
// across the blocks of a message. A finished block is held and presented to
// the compression core until it is acknowledged.
//
// Ports
//   clk, nreset          rising-edge clock, asynchronous active-low reset
//   data_v_i/data_i      byte strobe and value from the I/O interface
//   data_idx_i           byte lane within the current block
//   block_first_i/_last_i  byte belongs to the first / last block of a message
//   kk_i, ll_i           key length and message length in bytes
//   block_ack_i          compression core accepts the presented block
//   ready_v_o            buffer can accept bytes (forwarded to the host)
//   block_v_o            complete block presented
//   block_m_o            block data, byte k at bits [8k+7:8k]
//   block_first_o/_last_o  flags of the presented block
//   block_t_o            byte counter t for the presented block
//   err_o                sticky: a byte arrived while the buffer was full
module block_buffer (
  input  logic         clk,
  input  logic         nreset,
  input  logic         data_v_i,
  input  logic [7:0]   data_i,
  input  logic [5:0]   data_idx_i,
  input  logic         block_first_i,
  input  logic         block_last_i,
  input  logic [5:0]   kk_i,
  input  logic [63:0]  ll_i,
  input  logic         block_ack_i,
  output logic         ready_v_o,
  output logic         block_v_o,
  output logic [511:0] block_m_o,
  output logic         block_first_o,
  output logic         block_last_o,
  output logic [63:0]  block_t_o,
  output logic         err_o
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t       state_r, state_s;
  logic [511:0] buffer_r, buffer_s;
  logic [63:0]  cnt_r, cnt_s;
  logic [63:0]  blk_t_r, blk_t_s;
  logic         first_r, first_s;
  logic         blk_first_r, blk_first_s;
  logic         blk_last_r, blk_last_s;
  logic         err_r, err_s;
  logic         ready_r, ready_s;
  logic         valid_r, valid_s;

  logic         msg_start_s;
  logic [63:0]  cnt_upd_s;
  logic [63:0]  total_s;
  logic         empty_msg_s;
  logic         first_incl_s;
  logic         complete_s;

  // Derived per-byte conditions used by the next-state logic.
  always_comb begin
    msg_start_s  = block_first_i && (data_idx_i == 6'd0);
    // A message-start byte restarts the counter at one.
    if (msg_start_s) begin
      cnt_upd_s = 64'd1;
    end else begin
      cnt_upd_s = cnt_r + 64'd1;
    end
    // The key occupies a full, host-padded block ahead of the message.
    if (kk_i != 6'd0) begin
      total_s = ll_i + 64'd64;
    end else begin
      total_s = ll_i;
    end
    empty_msg_s = block_last_i && block_first_i && (total_s == 64'd0);
    // The first flag is sampled on lane 0; other lanes reuse the latched one.
    if (data_idx_i == 6'd0) begin
      first_incl_s = block_first_i;
    end else begin
      first_incl_s = first_r;
    end
    complete_s = (data_idx_i == 6'd63) || (block_last_i && (cnt_upd_s == total_s));
  end

  // Next-state and next-register logic of the FILL/FULL machine.
  always_comb begin
    state_s     = state_r;
    buffer_s    = buffer_r;
    cnt_s       = cnt_r;
    blk_t_s     = blk_t_r;
    first_s     = first_r;
    blk_first_s = blk_first_r;
    blk_last_s  = blk_last_r;
    err_s       = err_r;
    case (state_r)
      FILL: begin
        if (data_v_i) begin
          if (empty_msg_s) begin
            // Empty message: the byte is discarded, block completes as all-zero.
            buffer_s    = 512'd0;
            cnt_s       = 64'd0;
            blk_t_s     = 64'd0;
            first_s     = 1'b1;
            blk_first_s = 1'b1;
            blk_last_s  = 1'b1;
            state_s     = FULL;
          end else begin
            buffer_s[{data_idx_i, 3'b000} +: 8] = data_i;
            cnt_s   = cnt_upd_s;
            first_s = first_incl_s;
            if (complete_s) begin
              blk_t_s     = cnt_upd_s;
              blk_first_s = first_incl_s;
              blk_last_s  = block_last_i;
              state_s     = FULL;
            end else begin
              state_s = FILL;
            end
          end
        end else begin
          state_s = FILL;
        end
      end
      FULL: begin
        // Bytes arriving while a block is held are dropped and flagged.
        if (data_v_i) begin
          err_s = 1'b1;
        end else begin
          err_s = err_r;
        end
        if (block_ack_i) begin
          buffer_s = 512'd0;
          first_s  = 1'b0;
          state_s  = FILL;
        end else begin
          state_s = FULL;
        end
      end
      default: begin
        state_s = FILL;
      end
    endcase
    ready_s = (state_s == FILL);
    valid_s = (state_s == FULL);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r     <= FILL;
      buffer_r    <= 512'd0;
      cnt_r       <= 64'd0;
      blk_t_r     <= 64'd0;
      first_r     <= 1'b0;
      blk_first_r <= 1'b0;
      blk_last_r  <= 1'b0;
      err_r       <= 1'b0;
      ready_r     <= 1'b1;
      valid_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      buffer_r    <= buffer_s;
      cnt_r       <= cnt_s;
      blk_t_r     <= blk_t_s;
      first_r     <= first_s;
      blk_first_r <= blk_first_s;
      blk_last_r  <= blk_last_s;
      err_r       <= err_s;
      ready_r     <= ready_s;
      valid_r     <= valid_s;
    end
  end

  assign ready_v_o     = ready_r;
  assign block_v_o     = valid_r;
  assign block_m_o     = buffer_r;
  assign block_first_o = blk_first_r;
  assign block_last_o  = blk_last_r;
  assign block_t_o     = blk_t_r;
  assign err_o         = err_r;

endmodule

// File: tb/tb_block_buffer.sv
module tb_block_buffer;

  logic         clk = 1'b0;
  logic         nreset;
  logic         data_v_i;
  logic [7:0]   data_i;
  logic [5:0]   data_idx_i;
  logic         block_first_i;
  logic         block_last_i;
  logic [5:0]   kk_i;
  logic [63:0]  ll_i;
  logic         block_ack_i;
  logic         ready_v_o;
  logic         block_v_o;
  logic [511:0] block_m_o;
  logic         block_first_o;
  logic         block_last_o;
  logic [63:0]  block_t_o;
  logic         err_o;

  typedef struct {
    logic [511:0] m;
    logic [63:0]  t;
    logic         f;
    logic         l;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;
  logic hold_ack = 1'b0;
  logic prev_v = 1'b0;

  always #5 clk = ~clk;

  block_buffer dut (
    .clk(clk), .nreset(nreset), .data_v_i(data_v_i), .data_i(data_i),
    .data_idx_i(data_idx_i), .block_first_i(block_first_i),
    .block_last_i(block_last_i), .kk_i(kk_i), .ll_i(ll_i),
    .block_ack_i(block_ack_i), .ready_v_o(ready_v_o), .block_v_o(block_v_o),
    .block_m_o(block_m_o), .block_first_o(block_first_o),
    .block_last_o(block_last_o), .block_t_o(block_t_o), .err_o(err_o)
  );

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic chk_reset_values();
    chk("rst_ready", {511'd0, ready_v_o}, 512'd1);
    chk("rst_block_v", {511'd0, block_v_o}, 512'd0);
    chk("rst_block_m", block_m_o, 512'd0);
    chk("rst_first", {511'd0, block_first_o}, 512'd0);
    chk("rst_last", {511'd0, block_last_o}, 512'd0);
    chk("rst_t", {448'd0, block_t_o}, 512'd0);
    chk("rst_err", {511'd0, err_o}, 512'd0);
  endtask

  // Ack driver: random ack (also in FILL, where it must be ignored).
  always @(negedge clk) begin
    block_ack_i = !hold_ack && ($urandom_range(0, 2) == 0);
  end

  // Monitor: compares each newly presented block with the scoreboard.
  always @(negedge clk) begin
    if (nreset) begin
      chk("ready_vs_valid", {511'd0, ready_v_o}, {511'd0, !block_v_o});
      if (block_v_o && !prev_v) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_block: got t=%0d expected no block", block_t_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("block_m", block_m_o, e.m);
          chk("block_t", {448'd0, block_t_o}, {448'd0, e.t});
          chk("block_first", {511'd0, block_first_o}, {511'd0, e.f});
          chk("block_last", {511'd0, block_last_o}, {511'd0, e.l});
        end
      end
      if (!block_v_o && prev_v) begin
        chk("cleared_after_ack", block_m_o, 512'd0);
      end
    end
    prev_v = block_v_o;
  end

  // Present one byte at a negedge once the buffer is ready (random idle gaps).
  task automatic drive_byte(input logic [7:0] d, input logic [5:0] idx, input logic f,
                            input logic l, input logic [5:0] kk, input logic [63:0] ll);
    int waited = 0;
    forever begin
      @(negedge clk);
      data_v_i = 1'b0;
      if (ready_v_o && ($urandom_range(0, 3) != 0)) break;
      waited++;
      if (waited > 500) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: got ready=0 for %0d cycles expected ready", waited);
        finish_run();
      end
    end
    data_v_i      = 1'b1;
    data_i        = d;
    data_idx_i    = idx;
    block_first_i = f;
    block_last_i  = l;
    kk_i          = kk;
    ll_i          = ll;
  endtask

  // Reference model: split key block + message into 64-byte blocks.
  task automatic send_msg(input int kk, input int ll);
    logic [7:0] bytes[$];
    int len, nb, lo, hi;
    exp_t e;
    bytes = {};
    if (kk != 0) begin
      for (int i = 0; i < 64; i++) bytes.push_back((i < kk) ? 8'($urandom) : 8'd0);
    end
    for (int i = 0; i < ll; i++) bytes.push_back(8'($urandom));
    len = bytes.size();
    if (len == 0) begin
      e.m = 512'd0; e.t = 64'd0; e.f = 1'b1; e.l = 1'b1;
      exp_q.push_back(e);
      last_exp = e;
      drive_byte(8'($urandom_range(1, 255)), 6'd0, 1'b1, 1'b1, 6'(kk), 64'(ll));
    end else begin
      nb = (len + 63) / 64;
      for (int b = 0; b < nb; b++) begin
        lo = 64 * b;
        hi = (len < lo + 64) ? len : lo + 64;
        e.m = 512'd0;
        for (int j = lo; j < hi; j++) e.m[8 * (j - lo) +: 8] = bytes[j];
        e.t = 64'(hi);
        e.f = (b == 0);
        e.l = (b == nb - 1);
        exp_q.push_back(e);
        last_exp = e;
        for (int j = lo; j < hi; j++) begin
          drive_byte(bytes[j], 6'(j - lo), (b == 0), (b == nb - 1), 6'(kk), 64'(ll));
        end
      end
    end
  endtask

  task automatic drain();
    @(negedge clk);
    data_v_i = 1'b0;
    for (int i = 0; i < 3000 && (exp_q.size() != 0 || block_v_o); i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending blocks expected 0", exp_q.size());
      finish_run();
    end
  endtask

  initial begin
    nreset = 1'b0; data_v_i = 1'b0; data_i = 8'd0; data_idx_i = 6'd0;
    block_first_i = 1'b0; block_last_i = 1'b0; kk_i = 6'd0; ll_i = 64'd0;
    block_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_values();
    nreset = 1'b1;

    // Directed messages from the plan, then the empty message.
    send_msg(0, 64);
    send_msg(0, 3);
    send_msg(0, 100);
    send_msg(32, 2);
    send_msg(0, 0);
    send_msg(0, 128);
    send_msg(16, 0);
    for (int n = 0; n < 12; n++) begin
      send_msg(($urandom_range(0, 1) == 1) ? $urandom_range(1, 32) : 0, $urandom_range(0, 150));
    end
    drain();
    chk("err_clean", {511'd0, err_o}, 512'd0);

    // Overflow: block held with ack low while bytes keep arriving.
    hold_ack = 1'b1;
    send_msg(0, 64);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      data_v_i = 1'b1; data_i = 8'h5A; data_idx_i = 6'(i); block_first_i = 1'b1; block_last_i = 1'b1;
    end
    @(negedge clk);
    data_v_i = 1'b0;
    chk("ovf_err", {511'd0, err_o}, 512'd1);
    chk("ovf_ready", {511'd0, ready_v_o}, 512'd0);
    chk("ovf_valid", {511'd0, block_v_o}, 512'd1);
    chk("ovf_block_held", block_m_o, last_exp.m);
    chk("ovf_t_held", {448'd0, block_t_o}, {448'd0, last_exp.t});
    hold_ack = 1'b0;
    drain();
    chk("err_sticky", {511'd0, err_o}, 512'd1);

    // Reset in the middle of a block.
    for (int i = 0; i < 10; i++) drive_byte(8'($urandom), 6'(i), 1'b1, 1'b1, 6'd0, 64'd64);
    @(negedge clk);
    data_v_i = 1'b0;
    #2 nreset = 1'b0;
    #1 chk_reset_values();
    repeat (2) @(negedge clk);
    #2 nreset = 1'b1;
    send_msg(0, 64);
    drain();

    finish_run();
  end

endmodule
